// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub datapath.
// Default geometry and operation-select encoding.
package pipe_add_sub_pkg;

    localparam int DefDataWidth = 64;
    localparam int DefStages    = 4;

    typedef enum logic {
        OpAdd = 1'b0,
        OpSub = 1'b1
    } opSel_e;

endpackage

// File: rtl/pipe_add_sub_if.sv
// Operand/result handshake bundle for pipe_add_sub.
// slave is the datapath view, master the producer/consumer view.
interface pipe_add_sub_if #(
    parameter int DATA_WIDTH = pipe_add_sub_pkg::DefDataWidth
);

    logic                  IN_VALID;
    logic                  IN_READY;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  SnA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DATA_WIDTH-1:0] Y;
    logic                  CO;
    logic                  OVF;
    logic                  ZERO;

    modport slave (
        input  IN_VALID, A, B, SnA, OUT_READY,
        output IN_READY, OUT_VALID, Y, CO, OVF, ZERO
    );

    modport master (
        output IN_VALID, A, B, SnA, OUT_READY,
        input  IN_READY, OUT_VALID, Y, CO, OVF, ZERO
    );

endinterface

// File: rtl/pipe_add_sub_slice.sv
// rc_add_slice: combinational SW-bit ripple-carry adder slice
// with carry-out and slice-is-zero flag.
module rc_add_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] aSlice,
    input  logic [SW-1:0] bSlice,
    input  logic          carryIn,
    output logic [SW-1:0] sumSlice,
    output logic          carryOut,
    output logic          sliceZero
);

    logic [SW:0] c;

    always_comb begin
        c        = '0;
        sumSlice = '0;
        c[0]     = carryIn;
        for (int i = 0; i < SW; i++) begin
            sumSlice[i] = aSlice[i] ^ bSlice[i] ^ c[i];
            c[i+1]      = (aSlice[i] & bSlice[i])
                        | (c[i] & (aSlice[i] ^ bSlice[i]));
        end
    end

    assign carryOut  = c[SW];
    assign sliceZero = (sumSlice == '0);

endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined ripple-carry add/sub, one SW-bit slice
// per stage, valid/ready flow control, CO/OVF/ZERO flags.
module pipe_add_sub
    import pipe_add_sub_pkg::*;
#(
    parameter int DATA_WIDTH = DefDataWidth,
    parameter int STAGES     = DefStages
) (
    input  logic          CLK,
    input  logic          RST,
    pipe_add_sub_if.slave bus
);

    localparam int SW = DATA_WIDTH / STAGES;

    opSel_e op;

    assign op           = opSel_e'(bus.SnA);
    assign bus.IN_READY = gStage[0].rdy;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int InW  = DATA_WIDTH - k * SW;
        localparam int ResW = (k + 1) * SW;

        logic            validQ;
        logic            carryQ;
        logic            zeroQ;
        logic [ResW-1:0] resQ;
        logic [ResW-1:0] nextRes;
        logic            rdy;
        logic            upValid;
        logic            upCarry;
        logic            upZero;
        logic [InW-1:0]  upA;
        logic [InW-1:0]  upB;
        logic [SW-1:0]   sum;
        logic            sumCarry;
        logic            sumZero;

        // Operands shift down as slices are consumed; slice k is always at bit 0.
        if (k == 0) begin : gSrc
            assign upValid = bus.IN_VALID;
            assign upA     = bus.A;
            assign upB     = (op == OpSub) ? ~bus.B : bus.B;
            assign upCarry = (op == OpSub);
            assign upZero  = 1'b1;
            assign nextRes = sum;
        end else begin : gSrc
            assign upValid = gStage[k-1].validQ;
            assign upA     = gStage[k-1].gOps.aQ;
            assign upB     = gStage[k-1].gOps.bQ;
            assign upCarry = gStage[k-1].carryQ;
            assign upZero  = gStage[k-1].zeroQ;
            assign nextRes = {sum, gStage[k-1].resQ};
        end

        rc_add_slice #(
            .SW(SW)
        ) uSlice (
            .aSlice   (upA[SW-1:0]),
            .bSlice   (upB[SW-1:0]),
            .carryIn  (upCarry),
            .sumSlice (sum),
            .carryOut (sumCarry),
            .sliceZero(sumZero)
        );

        if (k == STAGES - 1) begin : gRdy
            assign rdy = !validQ | bus.OUT_READY;
        end else begin : gRdy
            assign rdy = !validQ | gStage[k+1].rdy;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                validQ <= 1'b0;
                carryQ <= 1'b0;
                zeroQ  <= 1'b0;
                resQ   <= '0;
            end else if (rdy) begin
                validQ <= upValid;
                if (upValid) begin
                    carryQ <= sumCarry;
                    zeroQ  <= upZero & sumZero;
                    resQ   <= nextRes;
                end
            end
        end

        if (k < STAGES - 1) begin : gOps
            localparam int RemW = InW - SW;

            logic [RemW-1:0] aQ;
            logic [RemW-1:0] bQ;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    aQ <= '0;
                    bQ <= '0;
                end else if (rdy && upValid) begin
                    aQ <= upA[InW-1:SW];
                    bQ <= upB[InW-1:SW];
                end
            end
        end else begin : gOut
            logic ovfQ;
            logic ovfNext;

            // Top slice holds the A and conditioned-B sign bits.
            assign ovfNext = (upA[SW-1] == upB[SW-1])
                           & (sum[SW-1] != upA[SW-1]);

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ovfQ <= 1'b0;
                end else if (rdy && upValid) begin
                    ovfQ <= ovfNext;
                end
            end

            assign bus.OUT_VALID = validQ;
            assign bus.Y         = resQ;
            assign bus.CO        = carryQ;
            assign bus.OVF       = ovfQ;
            assign bus.ZERO      = zeroQ;
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed vectors, stalled stream,
// mid-flight reset and a STAGES/DATA_WIDTH sweep against an arithmetic model.
module tb_pipe_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    pipe_add_sub_if #(.DATA_WIDTH(64)) m   ();
    pipe_add_sub_if #(.DATA_WIDTH(32)) s1  ();
    pipe_add_sub_if #(.DATA_WIDTH(64)) s2  ();
    pipe_add_sub_if #(.DATA_WIDTH(32)) s8  ();
    pipe_add_sub_if #(.DATA_WIDTH(64)) s8w ();

    pipe_add_sub #(.DATA_WIDTH(64), .STAGES(4)) dut (
        .CLK(clk), .RST(rst), .bus(m.slave));
    pipe_add_sub #(.DATA_WIDTH(32), .STAGES(1)) dut1 (
        .CLK(clk), .RST(rst), .bus(s1.slave));
    pipe_add_sub #(.DATA_WIDTH(64), .STAGES(2)) dut2 (
        .CLK(clk), .RST(rst), .bus(s2.slave));
    pipe_add_sub #(.DATA_WIDTH(32), .STAGES(8)) dut8 (
        .CLK(clk), .RST(rst), .bus(s8.slave));
    pipe_add_sub #(.DATA_WIDTH(64), .STAGES(8)) dut8w (
        .CLK(clk), .RST(rst), .bus(s8w.slave));

    logic        swValid = 1'b0;
    logic        swSna   = 1'b0;
    logic [63:0] swA     = '0;
    logic [63:0] swB     = '0;

    assign s1.IN_VALID  = swValid;
    assign s1.A         = swA[31:0];
    assign s1.B         = swB[31:0];
    assign s1.SnA       = swSna;
    assign s1.OUT_READY = 1'b1;
    assign s2.IN_VALID  = swValid;
    assign s2.A         = swA;
    assign s2.B         = swB;
    assign s2.SnA       = swSna;
    assign s2.OUT_READY = 1'b1;
    assign s8.IN_VALID  = swValid;
    assign s8.A         = swA[31:0];
    assign s8.B         = swB[31:0];
    assign s8.SnA       = swSna;
    assign s8.OUT_READY = 1'b1;
    assign s8w.IN_VALID  = swValid;
    assign s8w.A         = swA;
    assign s8w.B         = swB;
    assign s8w.SnA       = swSna;
    assign s8w.OUT_READY = 1'b1;

    logic        hv [48];
    logic [63:0] ha [48];
    logic [63:0] hb [48];
    logic        hs [48];

    // Reference: plain w-bit arithmetic, signed overflow by range check.
    function automatic logic [66:0] refOp(input logic [63:0] a, input logic [63:0] b,
                                          input logic sna, input int w);
        logic [63:0]        mask;
        logic [63:0]        y;
        logic [64:0]        full;
        logic               co;
        logic               ovf;
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] sr;
        logic signed [65:0] lim;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = b & mask;
        if (sna) begin
            full = {1'b0, a} - {1'b0, b};
            co   = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            co   = full[w];
        end
        y  = full[63:0] & mask;
        sa = $signed({2'b00, a});
        sb = $signed({2'b00, b});
        if (a[w-1]) sa = sa - (66'sd1 <<< w);
        if (b[w-1]) sb = sb - (66'sd1 <<< w);
        sr  = sna ? (sa - sb) : (sa + sb);
        lim = 66'sd1 <<< (w - 1);
        ovf = (sr >= lim) || (sr < -lim);
        return {co, ovf, (y == 64'd0), y};
    endfunction

    function automatic logic [66:0] mOut();
        return {m.CO, m.OVF, m.ZERO, m.Y};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input string tag, input logic [63:0] a,
                               input logic [63:0] b, input logic sna,
                               input logic [66:0] want);
        logic [3:0] pat;
        m.A         = a;
        m.B         = b;
        m.SnA       = sna;
        m.IN_VALID  = 1'b1;
        m.OUT_READY = 1'b1;
        #1;
        chk({tag, " ready"}, m.IN_READY, 1'b1);
        tick();
        m.IN_VALID = 1'b0;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            pat[i] = m.OUT_VALID;
            if (i < 3) tick();
        end
        chk({tag, " latency"}, pat, 4'b1000);
        chk({tag, " result"}, mOut(), want);
        tick();
    endtask

    task automatic checkSw(input string tag, input int s, input int w, input int c,
                           input logic [1:0] hsObs, input logic [66:0] obs);
        int   idx;
        logic ev;
        idx = c - (s - 1);
        ev  = (idx >= 0) ? hv[idx] : 1'b0;
        chk({tag, " valid"}, hsObs, {1'b1, ev});
        if (ev) chk({tag, " data"}, obs, refOp(ha[idx], hb[idx], hs[idx], w));
    endtask

    initial begin
        int          sent;
        int          got;
        int          inFlight;
        logic        prevStall;
        logic        seen;
        logic [66:0] prevSnap;
        logic [66:0] expQ [$];
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;

        m.IN_VALID  = 1'b0;
        m.A         = '0;
        m.B         = '0;
        m.SnA       = 1'b0;
        m.OUT_READY = 1'b1;
        ra = '0;
        rb = '0;
        rs = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("reset outputs", {m.OUT_VALID, mOut()}, 68'd0);
        chk("reset in_ready", m.IN_READY, 1'b1);
        tick();
        tick();
        rst = 1'b0;

        runDirected("add 1+1", 64'h1, 64'h1, 1'b0, {3'b000, 64'h2});
        runDirected("add wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    {3'b101, 64'h0});
        runDirected("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    {3'b010, 64'h8000_0000_0000_0000});
        runDirected("sub 7-3", 64'h7, 64'h3, 1'b1, {3'b100, 64'h4});
        runDirected("sub 0-1", 64'h0, 64'h1, 1'b1,
                    {3'b000, 64'hFFFF_FFFF_FFFF_FFFF});
        runDirected("sub wide", 64'hFF00_0000_0000_0000, 64'hEEEE_EEEE_EEEE_EEEE,
                    1'b1, {3'b100, 64'h1011_1111_1111_1112});

        sent      = 0;
        got       = 0;
        inFlight  = 0;
        prevStall = 1'b0;
        prevSnap  = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            m.OUT_READY = !(cyc >= 5 && cyc < 11);
            if (sent < 10) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                m.A        = ra;
                m.B        = rb;
                m.SnA      = rs;
                m.IN_VALID = 1'b1;
            end else begin
                m.IN_VALID = 1'b0;
            end
            #1;
            if (prevStall) chk("stall hold", {m.OUT_VALID, mOut()}, {1'b1, prevSnap});
            chk("stream in_ready", m.IN_READY, (inFlight < 4) || m.OUT_READY);
            if (m.OUT_VALID && m.OUT_READY) begin
                if (expQ.size() == 0) begin
                    chk("stream extra", m.OUT_VALID, 1'b0);
                end else begin
                    chk("stream data", mOut(), expQ.pop_front());
                    got++;
                    inFlight--;
                end
            end
            prevStall = m.OUT_VALID && !m.OUT_READY;
            prevSnap  = mOut();
            if (m.IN_VALID && m.IN_READY) begin
                expQ.push_back(refOp(ra, rb, rs, 64));
                sent++;
                inFlight++;
            end
            tick();
        end
        chk("stream count", got, 10);

        m.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m.A        = 64'd5 + 64'(i);
            m.B        = 64'd6;
            m.SnA      = 1'b0;
            m.IN_VALID = 1'b1;
            tick();
        end
        m.IN_VALID = 1'b0;
        tick();
        chk("pre-reset valid", m.OUT_VALID, 1'b1);
        chk("pre-reset y", m.Y, 64'd11);
        rst = 1'b1;
        #1;
        chk("reset flush", {m.OUT_VALID, mOut()}, 68'd0);
        chk("reset flush ready", m.IN_READY, 1'b1);
        tick();
        rst         = 1'b0;
        m.OUT_READY = 1'b1;
        seen        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | m.OUT_VALID;
        end
        chk("no stale result", seen, 1'b0);
        runDirected("post-reset", 64'd9, 64'd9, 1'b0, {3'b000, 64'd18});

        for (int c = 0; c < 48; c++) begin
            swValid = ($urandom_range(0, 3) != 0);
            swA     = {$urandom, $urandom};
            swB     = {$urandom, $urandom};
            swSna   = 1'($urandom_range(0, 1));
            if (c % 7 == 3) begin
                swB   = swA;
                swSna = 1'b1;
            end
            if (c % 11 == 5) begin
                swA   = 64'hFFFF_FFFF_FFFF_FFFF;
                swB   = 64'h1;
                swSna = 1'b0;
            end
            hv[c] = swValid;
            ha[c] = swA;
            hb[c] = swB;
            hs[c] = swSna;
            tick();
            checkSw("s1 w32", 1, 32, c, {s1.IN_READY, s1.OUT_VALID},
                    {s1.CO, s1.OVF, s1.ZERO, 32'd0, s1.Y});
            checkSw("s2 w64", 2, 64, c, {s2.IN_READY, s2.OUT_VALID},
                    {s2.CO, s2.OVF, s2.ZERO, s2.Y});
            checkSw("s8 w32", 8, 32, c, {s8.IN_READY, s8.OUT_VALID},
                    {s8.CO, s8.OVF, s8.ZERO, 32'd0, s8.Y});
            checkSw("s8 w64", 8, 64, c, {s8w.IN_READY, s8w.OUT_VALID},
                    {s8w.CO, s8w.OVF, s8w.ZERO, s8w.Y});
        end
        swValid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
